// File: rtl/alu_serial_sequencer.sv
// rtl/alu_serial_sequencer.sv - bit-serial word sequencer driving one single-bit ALU slice
// Optional macro ALU_ZERO_FLAG_EN adds a registered zero flag output.
module alu_serial_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       OpCode,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             Cout,
   output logic             error,
`ifdef ALU_ZERO_FLAG_EN
   output logic             zero,
`endif
   output logic             sliceA,
   output logic             sliceB,
   output logic             sliceCin,
   output logic [3:0]       sliceOpCode,
   input  logic             sliceResult,
   input  logic             sliceCout
);

   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SHL = 4'b1001;
   localparam logic [3:0] OP_SHR = 4'b1010;
   localparam logic [3:0] OP_NOP = 4'b1111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q, b_q, acc;
   logic [3:0]       op_q;
   logic [IW-1:0]    idx;
   logic             carry;
   logic             err_pend;
   logic [IW-1:0]    idx_m1, idx_p1;
   logic             word_cout;
   logic             op_ok;

   assign idx_m1 = idx - IW'(1);
   assign idx_p1 = idx + IW'(1);
   assign op_ok  = (OpCode <= OP_SUB) || (OpCode == OP_SHL) || (OpCode == OP_SHR);

   // Shifts reuse the slice as a pass-through (A OR 0) on the neighbouring bit.
   always_comb begin
      sliceA      = 1'b0;
      sliceB      = 1'b0;
      sliceCin    = 1'b0;
      sliceOpCode = OP_NOP;
      if (state == RUN) begin
         case (op_q)
            OP_ADD: begin
               sliceOpCode = OP_ADD;
               sliceA      = a_q[idx];
               sliceB      = b_q[idx];
               sliceCin    = carry;
            end
            OP_SUB: begin
               sliceOpCode = OP_ADD;
               sliceA      = a_q[idx];
               sliceB      = ~b_q[idx];
               sliceCin    = carry;
            end
            OP_SHL: begin
               sliceOpCode = OP_OR;
               sliceA      = (idx == '0) ? 1'b0 : a_q[idx_m1];
            end
            OP_SHR: begin
               sliceOpCode = OP_OR;
               sliceA      = (idx == LAST) ? 1'b0 : a_q[idx_p1];
            end
            default: begin
               sliceOpCode = op_q;
               sliceA      = a_q[idx];
               sliceB      = b_q[idx];
            end
         endcase
      end
   end

   always_comb begin
      word_cout = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: word_cout = carry;
         OP_SHL:         word_cout = a_q[WIDTH-1];
         OP_SHR:         word_cout = a_q[0];
         default:        word_cout = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         acc      <= '0;
         err_pend <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         Cout     <= 1'b0;
         error    <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
         zero     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q      <= A;
                  b_q      <= B;
                  op_q     <= OpCode;
                  idx      <= '0;
                  carry    <= (OpCode == OP_ADD) ? Cin : (OpCode == OP_SUB);
                  busy     <= 1'b1;
                  err_pend <= ~op_ok;
                  state    <= op_ok ? RUN : DONE;
               end
            end
            RUN: begin
               acc[idx] <= sliceResult;
               if (op_q == OP_ADD || op_q == OP_SUB)
                  carry <= sliceCout;
               idx <= idx_p1;
               if (idx == LAST)
                  state <= DONE;
            end
            DONE: begin
               done   <= 1'b1;
               busy   <= 1'b0;
               result <= err_pend ? '0 : acc;
               Cout   <= err_pend ? 1'b0 : word_cout;
               error  <= err_pend;
`ifdef ALU_ZERO_FLAG_EN
               zero   <= ~err_pend && (acc == '0);
`endif
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
